// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte to the attached device. It inhibits the bus, issues
// a request-to-send, shifts out 8 data bits (LSB first), odd parity and stop,
// then checks the device acknowledge. The shared lines are driven through
// open-drain enables; the tri-state buffers live in the parent.
//
// Ports:
//   CLK, RST_X        system clock, asynchronous active-low reset
//   tx_data, tx_en    byte to send, one-cycle request (accepted only when idle)
//   busy              high while a transfer is in progress
//   done, err         one-cycle completion / failure pulses
//   ps2_clk_i/data_i  raw PS/2 line levels (asynchronous)
//   ps2_clk_oe/data_oe 1 = pull the line low
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       CLK,
    input  logic       RST_X,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_ERR
    } state_t;

    state_t        r_state;
    logic          r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
    logic          r_clk_filt, r_fall;
    logic [FW-1:0] r_fcnt;
    logic [7:0]    r_byte;
    logic          r_par;
    logic [IW-1:0] r_icnt;
    logic [TW-1:0] r_tcnt;
    logic [3:0]    r_idx;
    logic          r_busy, r_done, r_err, r_clk_oe, r_data_oe;
    logic          w_timed, w_timeout;

    // Synchronizers reset to 1 so an idle bus does not look like an edge.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk_i;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= ps2_data_i;
            r_dat_sync <= r_dat_meta;
        end
    end

    // Glitch filter: the filtered clock flips only after FILTER_LEN
    // consecutive samples disagree with it. r_fall strobes with a 1->0 flip.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_clk_filt <= 1'b1;
            r_fcnt     <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_sync == r_clk_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt >= FLT_LAST) begin
                r_clk_filt <= r_clk_sync;
                r_fcnt     <= '0;
                r_fall     <= r_clk_filt;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign w_timed   = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_timeout = w_timed && (r_tcnt >= TO_LAST);

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_byte    <= '0;
            r_par     <= 1'b0;
            r_icnt    <= '0;
            r_tcnt    <= '0;
            r_idx     <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_timed && !w_timeout)
                r_tcnt <= r_tcnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (tx_en) begin
                        r_byte    <= tx_data;
                        r_par     <= ~^tx_data;
                        r_icnt    <= '0;
                        r_state   <= S_INHIBIT;
                        r_busy    <= 1'b1;
                        r_clk_oe  <= 1'b1;
                        r_data_oe <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    if (r_icnt >= INH_LAST) begin
                        r_state   <= S_REQ;
                        r_data_oe <= 1'b1;      // start bit
                    end else begin
                        r_icnt <= r_icnt + 1'b1;
                    end
                end
                S_REQ: begin
                    r_state  <= S_SEND;
                    r_clk_oe <= 1'b0;
                    // Preloaded with 1: the count includes the current cycle,
                    // so ERR is entered on the edge the count reaches the limit.
                    r_tcnt   <= TW'(1);
                    r_idx    <= '0;
                end
                S_SEND: begin
                    if (w_timeout) begin
                        r_state   <= S_ERR;
                        r_data_oe <= 1'b0;
                    end else if (r_fall) begin
                        if (r_idx < 4'd8)
                            r_data_oe <= ~r_byte[r_idx[2:0]];
                        else if (r_idx == 4'd8)
                            r_data_oe <= ~r_par;
                        else begin
                            r_data_oe <= 1'b0;  // stop bit: release data
                            r_state   <= S_ACK;
                        end
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_ACK: begin
                    if (w_timeout)
                        r_state <= S_ERR;
                    else if (r_fall)
                        r_state <= r_dat_sync ? S_ERR : S_WAIT_IDLE;
                end
                S_WAIT_IDLE: begin
                    if (w_timeout) begin
                        r_state <= S_ERR;
                    end else if (r_clk_sync && r_dat_sync) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_ERR: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_err     <= 1'b1;
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (LED set 0xED, reset 0xFF, enable 0xF4, …) from the SoC to the attached keyboard.
- Counterpart of the keyboard receive path. It drives the shared PS/2 clock/data lines through open-drain enables; the top level builds the tri-states.
- While busy, the keyboard receive path must ignore bus activity.

Parameters:
- INHIBIT_CYCLES, 10000, CLK cycles the host holds PS/2 clock low before the request (100 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000, maximum CLK cycles from clock release until acknowledge (20 ms at 100 MHz).
- FILTER_LEN, 8, consecutive synchronized samples needed to accept a PS/2 clock level change.

Ports:
- CLK  input  1  system clock.
- RST_X  input  1  reset; asynchronous, active-low.
- tx_data  input  8  byte to send; sampled when tx_en is accepted.
- tx_en  input  1  one-cycle transmit request.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse: byte sent and device acknowledged.
- err  output  1  one-cycle pulse: timeout or missing acknowledge.
- ps2_clk_i  input  1  PS/2 clock line level (asynchronous).
- ps2_data_i  input  1  PS/2 data line level (asynchronous).
- ps2_clk_oe  output  1  1 = pull PS/2 clock low.
- ps2_data_oe  output  1  1 = pull PS/2 data low.

Behaviour:
- Reset: state IDLE; busy, done, err, ps2_clk_oe and ps2_data_oe all 0. Both lines are released immediately and asynchronously on RST_X low, including mid-transfer.
- Input conditioning:
  - ps2_clk_i and ps2_data_i each pass through a 2-FF synchronizer.
  - The filtered clock changes level only after FILTER_LEN consecutive equal synchronized samples.
  - A falling edge is a filtered 1->0 transition, one-cycle strobe.
- Acceptance: tx_en is accepted only in IDLE. It latches tx_data and parity = ~^tx_data (odd parity). tx_en outside IDLE is ignored with no error.
- busy = (state != IDLE), registered, so it goes high the cycle after acceptance.
- States:
  - IDLE -> INHIBIT on accepted tx_en.
  - INHIBIT: clk_oe=1, data_oe=0, for exactly INHIBIT_CYCLES cycles. Then -> REQ.
  - REQ: clk_oe=1, data_oe=1 (start bit) for 1 cycle. Then -> SEND with clk_oe=0; the timeout counter clears and starts.
  - SEND: bit index n=0..9 advances on each falling edge.
    - Edges 1–8: data_oe = ~tx_data[n], LSB first.
    - Edge 9: data_oe = ~parity.
    - Edge 10: data_oe = 0 (stop bit, line released). Then -> ACK.
  - ACK: on the next falling edge, sample filtered data. If 0 -> WAIT_IDLE; if 1 -> ERR.
  - WAIT_IDLE: wait until synchronized clock and data are both 1. Then -> IDLE with done=1 for that one cycle.
  - ERR: clk_oe=0 and data_oe=0. -> IDLE with err=1 for one cycle.
- Timeout: the counter runs in SEND, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES -> ERR, regardless of bit position.
- done and err are never asserted together. Each pulse coincides with the first cycle of busy=0.
- A new tx_en is accepted in the same cycle done/err pulses, because the state is already IDLE.
- Output updates: ps2_data_oe changes only in the cycle after an accepted falling edge (host writes while the device clock is low). ps2_clk_oe is 0 in every state except INHIBIT and REQ.
- Counters are sized with $clog2 of their limit; there is no wrap-around, and counters saturate or clear on state change.

Test Plan:
Bench uses INHIBIT_CYCLES=20, TIMEOUT_CYCLES=5000, FILTER_LEN=2, and a device BFM that clocks at 40 CLK/half-period and samples data on rising edges.
1. tx_data=0xED:
   - clk_oe high exactly 20 cycles, then 1 REQ cycle with data_oe=1.
   - BFM captures start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - BFM acks 0 -> done pulse once, busy falls the same cycle.
2. tx_data=0xF4 -> parity 0 captured. tx_data=0x00 -> parity 1. Both complete with done.
3. BFM never generates clocks after REQ -> err pulse exactly 5000 cycles after clk_oe drops; both oe=0; done never asserted.
4. BFM leaves data high on the ack clock -> err pulse; next tx_en 0xFF then completes normally with done.
5. tx_en asserted with 0x55 mid-transfer of 0xED -> ignored; BFM captures only 0xED; exactly one done.
6. RST_X low during bit 4 -> clk_oe, data_oe, busy = 0 asynchronously with no done/err. After release, 0xFF transfer succeeds.
